ram_data_lsu: RTL and testbench
===============================

Name: ram_data_lsu

Overview:
- Parametrised successor to the single-cycle data RAM: a byte-addressed data memory with a built-in load/store front end.
- Accepts one request at a time from the core's memory stage over a valid/ready handshake.
- Performs byte/halfword/word stores with generated byte enables, and loads with lane extraction and sign/zero extension.
- Flags misaligned accesses, and returns each response over a second valid/ready handshake with an optional extra pipeline stage.

Parameters:
- ADDR_WIDTH, 17, word-address width; the array holds 2**ADDR_WIDTH 32-bit words, and the byte address is ADDR_WIDTH+2 bits.
- OUT_REG, 0, 0 gives 1-cycle response latency; 1 inserts a registered stage, giving 2-cycle latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; resets control state only, not array contents.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal size.

Behaviour:
- Reset (async assert, sync release): state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. Array contents are undefined and are not cleared.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. Request fields are sampled only on that edge.
- Word index = req_addr[ADDR_WIDTH+1:2]; offset = req_addr[1:0].
- Error: err = (size == 3) || (size == 1 && offset[0]) || (size == 2 && offset != 0).
- Store, no error: on the accept edge, write byte lanes.
  - Byte: lane = offset, data = wdata[7:0] replicated.
  - Half: lanes {offset+1, offset}, data = wdata[15:0] replicated.
  - Word: all lanes.
  - Other lanes are unchanged.
- Store with error: no array write at all.
- Load: the array word is read on the accept edge into an internal register.
  - Lane select and extension: byte = word[8*offset +: 8], half = word[16*offset[1] +: 16]. Extend to 32 bits per req_unsigned.
  - Error loads return rdata = 0.
- FSM: IDLE → (OUT_REG ? BUSY : RESP) on accept. BUSY → RESP unconditionally. RESP → IDLE on rsp_valid && rsp_ready.
- rsp_valid = 1 only in RESP. rsp_rdata and rsp_err are stable while rsp_valid is high and rsp_ready is low.
- Latency: rsp_valid rises 1 clock after the accept edge (OUT_REG = 0) or 2 clocks after (OUT_REG = 1).
- Throughput: one outstanding request. req_ready = 0 in BUSY and RESP. The next accept is possible at the earliest on the edge after the RESP→IDLE edge.
- Read-after-write: a load accepted after a store's response completes sees the stored data; no forwarding is needed because requests are serialised.
- Backpressure: RESP holds indefinitely while rsp_ready = 0. req_valid is ignored while not IDLE.
- Reset mid-operation: an in-flight response is dropped and the FSM returns to IDLE. A store whose accept edge already occurred stays committed. A store sampled on the same edge as the reset assertion is not performed.
- Address wrap: there is none; the full ADDR_WIDTH+2 address is always in range.

Test Plan:
- Reset, then word store to 0x10 with 0xDEADBEEF, then word load from 0x10 → rsp_rdata = 0xDEADBEEF, rsp_err = 0. rsp_valid rises 1 cycle after accept with OUT_REG = 0, 2 cycles with OUT_REG = 1.
- After that, byte store 0x5A to 0x12, then word load from 0x10 → 0xDE5ABEEF.
  - Byte load from 0x13, signed → 0xFFFFFFDE; unsigned → 0x000000DE.
  - Half load from 0x12, signed → 0xFFFFDE5A.
- Half store to 0x11 (misaligned) → rsp_err = 1, rsp_rdata = 0. A following word load from 0x10 is unchanged at 0xDE5ABEEF. Word load from 0x12 → rsp_err = 1. req_size = 3 → rsp_err = 1.
- Hold rsp_ready = 0 for 5 cycles with a load response pending → rsp_valid stays high, data stable, req_ready = 0. A new req_valid during the stall is not accepted. Raising rsp_ready completes the handshake; the next request is accepted on the following edge.
- Assert rst_n = 0 while in RESP (and, with OUT_REG = 1, while in BUSY) → rsp_valid drops to 0 immediately (asynchronously) and req_ready = 1. A previously accepted store's data is still readable after reset release.
- Back-to-back random byte/half/word stores and loads over 1000 requests, with random rsp_ready stalls, checked against a byte-array reference model for both OUT_REG values → zero mismatches.

Source files
------------

// File: rtl/ram_data_lsu.sv
// Byte-addressed data RAM with a load/store front end: one request at a time,
// byte-enable stores, extended loads, misalignment flagging, optional output stage.
module ram_data_lsu #(
    parameter int ADDR_WIDTH = 17,
    parameter bit OUT_REG    = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH+1:0] req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            offset;
    logic                  req_err;
    logic [3:0]            wr_be;
    logic [31:0]           wr_data;
    logic [31:0]           rd_word;
    logic [31:0]           result;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;

    logic                  we_q;
    logic                  err_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [1:0]            off_q;

    assign accept   = req_valid_i && req_ready_o;
    assign word_idx = req_addr_i[ADDR_WIDTH+1:2];
    assign offset   = req_addr_i[1:0];

    always_comb begin
        req_err = (req_size_i == 2'd3)
               || (req_size_i == 2'd1 && offset[0])
               || (req_size_i == 2'd2 && offset != 2'd0);
        wr_be   = 4'b0000;
        wr_data = req_wdata_i;
        case (req_size_i)
            2'd0: begin
                wr_be   = 4'b0001 << offset;
                wr_data = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                wr_be   = 4'b0011 << offset;
                wr_data = {2{req_wdata_i[15:0]}};
            end
            2'd2:    wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
        // Loads and faulting stores leave the array untouched.
        if (!req_we_i || req_err) begin
            wr_be = 4'b0000;
        end
    end

    // One byte-wide RAM per lane, read-first, read registered on the accept edge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk_i) begin
            if (accept) begin
                if (wr_be[gi]) begin
                    mem[word_idx] <= wr_data[8*gi +: 8];
                end
                rd_q <= mem[word_idx];
            end
        end

        assign rd_word[8*gi +: 8] = rd_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            uns_q  <= 1'b0;
            size_q <= 2'd0;
            off_q  <= 2'd0;
        end else if (accept) begin
            we_q   <= req_we_i;
            err_q  <= req_err;
            uns_q  <= req_unsigned_i;
            size_q <= req_size_i;
            off_q  <= offset;
        end
    end

    always_comb begin
        result = '0;
        lane_b = rd_word[{off_q, 3'b000} +: 8];
        lane_h = rd_word[{off_q[1], 4'b0000} +: 16];
        if (!we_q && !err_q) begin
            case (size_q)
                2'd0:    result = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
                2'd1:    result = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
                default: result = rd_word;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = OUT_REG ? BUSY : RESP;
                end
            end
            BUSY: state_d = RESP;
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_err_o = (state_q == RESP) && err_q;

    // The optional stage captures the extended result during BUSY.
    if (OUT_REG) begin : g_out_reg
        logic [31:0] rdata_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rdata_q <= '0;
            end else if (state_q == BUSY) begin
                rdata_q <= result;
            end
        end

        assign rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
    end else begin : g_out_comb
        assign rsp_rdata_o = (state_q == RESP) ? result : '0;
    end

endmodule

// File: tb/tb_ram_data_lsu.sv
// Directed and random checks of ram_data_lsu, one instance per OUT_REG setting,
// against a byte-array reference model.
module tb_ram_data_lsu;
    localparam int AW = 8;
    localparam int AB = AW + 2;
    localparam int NB = 1 << AB;
    localparam logic [AB-1:0] INTRUDE_ADDR = 10'h300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n        [2];
    logic          req_valid    [2];
    logic          req_ready    [2];
    logic          req_we       [2];
    logic [AB-1:0] req_addr     [2];
    logic [1:0]    req_size     [2];
    logic          req_unsigned [2];
    logic [31:0]   req_wdata    [2];
    logic          rsp_valid    [2];
    logic          rsp_ready    [2];
    logic [31:0]   rsp_rdata    [2];
    logic          rsp_err      [2];

    logic [7:0] model [2][NB];
    int n_checks = 0;
    int n_errors = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ram_data_lsu #(
            .ADDR_WIDTH(AW),
            .OUT_REG   (gi == 1)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n[gi]),
            .req_valid_i   (req_valid[gi]),
            .req_ready_o   (req_ready[gi]),
            .req_we_i      (req_we[gi]),
            .req_addr_i    (req_addr[gi]),
            .req_size_i    (req_size[gi]),
            .req_unsigned_i(req_unsigned[gi]),
            .req_wdata_i   (req_wdata[gi]),
            .rsp_valid_o   (rsp_valid[gi]),
            .rsp_ready_i   (rsp_ready[gi]),
            .rsp_rdata_o   (rsp_rdata[gi]),
            .rsp_err_o     (rsp_err[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void exp_rsp(input int u, input logic we, input logic [AB-1:0] a,
                                    input logic [1:0] sz, input logic uns,
                                    output logic [31:0] rd, output logic er);
        int ai;
        ai = int'(a);
        er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        rd = '0;
        if (!we && !er) begin
            case (sz)
                2'd0: rd = uns ? {24'd0, model[u][ai]} : {{24{model[u][ai][7]}}, model[u][ai]};
                2'd1: rd = uns ? {16'd0, model[u][ai+1], model[u][ai]}
                               : {{16{model[u][ai+1][7]}}, model[u][ai+1], model[u][ai]};
                default: rd = {model[u][ai+3], model[u][ai+2], model[u][ai+1], model[u][ai]};
            endcase
        end
    endfunction

    task automatic model_store(input int u, input logic [AB-1:0] a, input logic [1:0] sz,
                               input logic [31:0] wd);
        int ai;
        ai = int'(a);
        model[u][ai] = wd[7:0];
        if (sz != 2'd0) model[u][ai+1] = wd[15:8];
        if (sz == 2'd2) begin
            model[u][ai+2] = wd[23:16];
            model[u][ai+3] = wd[31:24];
        end
    endtask

    task automatic xact(input int u, input logic we, input logic [AB-1:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input int stall, input bit intrude,
                        output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic        eer;
        int          n;
        exp_rsp(u, we, a, sz, uns, erd, eer);
        @(negedge clk);
        check("req_ready_idle", req_ready[u], 1);
        req_valid[u]    = 1'b1;
        req_we[u]       = we;
        req_addr[u]     = a;
        req_size[u]     = sz;
        req_unsigned[u] = uns;
        req_wdata[u]    = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                // Optionally keep offering a store that must be ignored while busy.
                req_valid[u] = intrude;
                req_we[u]    = 1'b1;
                req_addr[u]  = INTRUDE_ADDR;
                req_size[u]  = 2'd2;
                req_wdata[u] = 32'hBAD0BAD0;
            end
        end while (!rsp_valid[u] && n < 8);
        check("latency", n, u + 1);
        rd = rsp_rdata[u];
        er = rsp_err[u];
        check("rdata", rd, erd);
        check("err", er, eer);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid[u], 1);
            check("stall_rdata", rsp_rdata[u], rd);
            check("stall_ready", req_ready[u], 0);
        end
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        req_valid[u] = 1'b0;
        check("rsp_done", rsp_valid[u], 0);
        if (we && !eer) model_store(u, a, sz, wd);
        $display("u%0d %s a=%h sz=%0d uns=%0b wd=%h stall=%0d -> rd=%h err=%0b",
                 u, we ? "ST" : "LD", a, sz, uns, wd, stall, rd, er);
    endtask

    task automatic reset_mid(input int u, input int wait_n);
        logic [31:0] rd;
        logic        er;
        logic [31:0] wd;
        wd = 32'hC0DE0000 | wait_n;
        @(negedge clk);
        req_valid[u] = 1'b1;
        req_we[u]    = 1'b1;
        req_addr[u]  = 10'h040;
        req_size[u]  = 2'd2;
        req_wdata[u] = wd;
        for (int k = 0; k < wait_n; k++) @(negedge clk);
        req_valid[u] = 1'b0;
        rst_n[u] = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid[u], 0);
        check("rst_req_ready", req_ready[u], 1);
        check("rst_rsp_rdata", rsp_rdata[u], 0);
        check("rst_rsp_err", rsp_err[u], 0);
        model_store(u, 10'h040, 2'd2, wd);
        @(negedge clk);
        @(negedge clk);
        rst_n[u] = 1'b1;
        xact(u, 1'b0, 10'h040, 2'd2, 1'b0, 0, 0, 1'b0, rd, er);
        check("rst_store_kept", rd, wd);
        $display("u%0d reset after %0d cycles, store kept rd=%h", u, wait_n, rd);
    endtask

    task automatic run_unit(input int u);
        logic [31:0] rd;
        logic        er;
        int          r;
        logic [1:0]  sz;
        // Fill the whole array so every later load has a defined expectation.
        for (int i = 0; i < (1 << AW); i++) begin
            xact(u, 1'b1, AB'(i * 4), 2'd2, 1'b0, $urandom, 0, 1'b0, rd, er);
        end
        xact(u, 1'b1, 10'h010, 2'd2, 1'b0, 32'hDEADBEEF, 0, 1'b0, rd, er);
        check("st_w_err", er, 0);
        xact(u, 1'b0, 10'h010, 2'd2, 1'b0, 0, 0, 1'b0, rd, er);
        check("ld_w_dead", rd, 32'hDEADBEEF);
        check("ld_w_dead_err", er, 0);
        xact(u, 1'b1, 10'h012, 2'd0, 1'b0, 32'h0000005A, 0, 1'b0, rd, er);
        xact(u, 1'b0, 10'h010, 2'd2, 1'b0, 0, 0, 1'b0, rd, er);
        check("ld_w_after_b", rd, 32'hDE5ABEEF);
        xact(u, 1'b0, 10'h013, 2'd0, 1'b0, 0, 0, 1'b0, rd, er);
        check("ld_b_signed", rd, 32'hFFFFFFDE);
        xact(u, 1'b0, 10'h013, 2'd0, 1'b1, 0, 0, 1'b0, rd, er);
        check("ld_b_unsigned", rd, 32'h000000DE);
        xact(u, 1'b0, 10'h012, 2'd1, 1'b0, 0, 0, 1'b0, rd, er);
        check("ld_h_signed", rd, 32'hFFFFDE5A);
        xact(u, 1'b1, 10'h011, 2'd1, 1'b0, 32'h00001234, 0, 1'b0, rd, er);
        check("st_h_mis_err", er, 1);
        check("st_h_mis_rdata", rd, 0);
        xact(u, 1'b0, 10'h010, 2'd2, 1'b0, 0, 0, 1'b0, rd, er);
        check("ld_w_unchanged", rd, 32'hDE5ABEEF);
        xact(u, 1'b0, 10'h012, 2'd2, 1'b0, 0, 0, 1'b0, rd, er);
        check("ld_w_mis_err", er, 1);
        check("ld_w_mis_rdata", rd, 0);
        xact(u, 1'b0, 10'h010, 2'd3, 1'b0, 0, 0, 1'b0, rd, er);
        check("size3_err", er, 1);
        // Stalled response with a competing request that must not be taken.
        xact(u, 1'b0, 10'h010, 2'd2, 1'b0, 0, 5, 1'b1, rd, er);
        check("stall_ld", rd, 32'hDE5ABEEF);
        xact(u, 1'b0, INTRUDE_ADDR, 2'd2, 1'b0, 0, 0, 1'b0, rd, er);
        check("intrude_ignored_ne", rd == 32'hBAD0BAD0, 0);
        reset_mid(u, 1);
        if (u == 1) reset_mid(u, 2);
        for (int i = 0; i < 1000; i++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            xact(u, 1'($urandom_range(0, 1)), AB'($urandom_range(0, 63)), sz,
                 1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                 1'($urandom_range(0, 1)), rd, er);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u]        = 1'b0;
            req_valid[u]    = 1'b0;
            req_we[u]       = 1'b0;
            req_addr[u]     = '0;
            req_size[u]     = 2'd0;
            req_unsigned[u] = 1'b0;
            req_wdata[u]    = '0;
            rsp_ready[u]    = 1'b0;
        end
        #1;
        for (int u = 0; u < 2; u++) begin
            check("reset_req_ready", req_ready[u], 1);
            check("reset_rsp_valid", rsp_valid[u], 0);
            check("reset_rsp_rdata", rsp_rdata[u], 0);
            check("reset_rsp_err", rsp_err[u], 0);
        end
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        for (int u = 0; u < 2; u++) run_unit(u);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
